// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage of the pipeline.
// Selects the write-back value from the MEM/WB latch and commits it to a
// 32x32 integer register file with x0 hardwired to zero. Also provides the two
// combinational ID-stage read ports and a retired-instruction counter.
// Optional feature macro: WB_BYPASS_EN adds write-before-read forwarding on
// both read ports. When it is undefined, the read ports always return stored
// contents, and the hazard unit has to cover same-cycle readers.

module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic [XLEN-1:0]  data_i,
  input  logic [XLEN-1:0]  Readdata_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             wb_en_o,
  output logic [CNT_W-1:0] instret_o
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  // Write-back value selection and effective write enable (x0 and bubbles never write)
  always_comb begin
    wb_data_o = MemtoReg_i ? Readdata_i : data_i;
    wb_en_o   = valid_i & RegWrite_i & (rd_i != 5'd0);
  end

  // Next-state of the register file and the retired-instruction counter
  always_comb begin
    regs_d    = regs_q;
    instret_d = instret_q;
    if (wb_en_o) begin
      regs_d[rd_i] = wb_data_o;
    end
    if (valid_i) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // State registers, cleared immediately while reset is held low
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regs_q    <= '{default: '0};
      instret_q <= '0;
    end else begin
      regs_q    <= regs_d;
      instret_q <= instret_d;
    end
  end

  // Read port 1: zero for x0 and during reset, optionally forwarded from write-back
  always_comb begin
    rs1_data_o = '0;
    if (rst_i && (rs1_i != 5'd0)) begin
      rs1_data_o = regs_q[rs1_i];
`ifdef WB_BYPASS_EN
      if (wb_en_o && (rs1_i == rd_i)) begin
        rs1_data_o = wb_data_o;
      end
`else
`endif
    end
  end

  // Read port 2: same rules as read port 1
  always_comb begin
    rs2_data_o = '0;
    if (rst_i && (rs2_i != 5'd0)) begin
      rs2_data_o = regs_q[rs2_i];
`ifdef WB_BYPASS_EN
      if (wb_en_o && (rs2_i == rd_i)) begin
        rs2_data_o = wb_data_o;
      end
`else
`endif
    end
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile.
// Directed vector table, hand-written reset/X sequences, then randomized
// traffic compared against an array-based architectural model. A second
// instance with an 8-bit counter exercises counter wraparound.

module tb_wb_regfile;

   localparam int XLEN = 32;
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk;
   logic            rstN;
   logic            valid;
   logic            regWrite;
   logic            memToReg;
   logic [XLEN-1:0] data;
   logic [XLEN-1:0] readData;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] rs1Data;
   logic [XLEN-1:0] rs2Data;
   logic [XLEN-1:0] wbData;
   logic            wbEn;
   logic [63:0]     instret;
   logic [XLEN-1:0] rs1Data8;
   logic [XLEN-1:0] rs2Data8;
   logic [XLEN-1:0] wbData8;
   logic            wbEn8;
   logic [7:0]      instret8;

   int errors = 0;
   int checks = 0;

   // Architectural model: plain array plus counter
   logic [XLEN-1:0] modelRegs [32];
   logic [63:0]     modelCnt;

   typedef struct {
      logic        valid;
      logic        regWrite;
      logic        memToReg;
      logic [31:0] data;
      logic [31:0] readData;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] expWbData;
      logic        expWbEn;
      logic [31:0] expRs1;
      logic [31:0] expRs2;
      logic [63:0] expCnt;
   } vec_t;

   vec_t vecs [8];

   wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(64)) dut (
      .clk_i(clk), .rst_i(rstN), .valid_i(valid), .RegWrite_i(regWrite),
      .MemtoReg_i(memToReg), .data_i(data), .Readdata_i(readData), .rd_i(rd),
      .rs1_i(rs1), .rs2_i(rs2), .rs1_data_o(rs1Data), .rs2_data_o(rs2Data),
      .wb_data_o(wbData), .wb_en_o(wbEn), .instret_o(instret)
   );

   wb_regfile #(.XLEN(32), .NREG(32), .CNT_W(8)) dut8 (
      .clk_i(clk), .rst_i(rstN), .valid_i(valid), .RegWrite_i(regWrite),
      .MemtoReg_i(memToReg), .data_i(data), .Readdata_i(readData), .rd_i(rd),
      .rs1_i(rs1), .rs2_i(rs2), .rs1_data_o(rs1Data8), .rs2_data_o(rs2Data8),
      .wb_data_o(wbData8), .wb_en_o(wbEn8), .instret_o(instret8)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic rw, input logic m2r,
                                input logic [31:0] d, input logic [31:0] rdat,
                                input logic [4:0] dst, input logic [4:0] s1, input logic [4:0] s2);
      valid    = v;
      regWrite = rw;
      memToReg = m2r;
      data     = d;
      readData = rdat;
      rd       = dst;
      rs1      = s1;
      rs2      = s2;
   endtask

   // Expected read value from the model for the current cycle's inputs
   function automatic logic [31:0] expRead(input logic [4:0] idx);
      logic        wen;
      logic [31:0] wv;
      wen = valid && regWrite && (rd != 5'd0);
      wv  = memToReg ? readData : data;
      if (idx == 5'd0) return 32'd0;
      if (BYP && wen && (idx == rd)) return wv;
      return modelRegs[idx];
   endfunction

   // Advance the model by one rising edge using the current inputs
   task automatic modelCommit();
      if (valid && regWrite && (rd != 5'd0))
         modelRegs[rd] = memToReg ? readData : data;
      if (valid) modelCnt = modelCnt + 64'd1;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) modelRegs[i] = '0;
      modelCnt = '0;
   endtask

   initial begin
      // Directed vectors, starting from a freshly reset state
      vecs[0] = '{1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 5'd3, 5'd3, 5'd0,
                  32'hDEADBEEF, 1'b1, (BYP ? 32'hDEADBEEF : 32'h0), 32'h0, 64'd0};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h11111111, 32'h00C0FFEE, 5'd4, 5'd3, 5'd4,
                  32'h00C0FFEE, 1'b1, 32'hDEADBEEF, (BYP ? 32'h00C0FFEE : 32'h0), 64'd1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd4,
                  32'hFFFFFFFF, 1'b0, 32'h0, 32'h00C0FFEE, 64'd2};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h00000055, 32'h0, 5'd7, 5'd7, 5'd0,
                  32'h00000055, 1'b0, 32'h0, 32'h0, 64'd3};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0, 5'd9, 5'd9, 5'd9,
                  32'hA5A5A5A5, 1'b1, (BYP ? 32'hA5A5A5A5 : 32'h0), (BYP ? 32'hA5A5A5A5 : 32'h0), 64'd3};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0, 5'd9, 5'd9, 5'd7,
                  32'h12345678, 1'b0, 32'hA5A5A5A5, 32'h0, 64'd4};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 5'd3, 5'd9, 5'd3,
                  32'h0BADF00D, 1'b0, 32'hA5A5A5A5, 32'hDEADBEEF, 64'd5};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0,
                  32'h0, 1'b0, 32'h00C0FFEE, 32'h0, 64'd5};

      // Reset held with the clock running: every register reads zero
      rstN = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'hCAFE0000, 32'h0, 5'd2, 5'd0, 5'd0);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         #1;
         checkOutput("reset_rs1", 64'(rs1Data), 64'd0);
         checkOutput("reset_rs2", 64'(rs2Data), 64'd0);
      end
      checkOutput("reset_instret", instret, 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      rstN = 1'b1;
      modelReset();
      @(posedge clk);
      #1;

      // Directed table
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].regWrite, vecs[i].memToReg, vecs[i].data,
                       vecs[i].readData, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
         #2;
         checkOutput($sformatf("vec%0d_wb_data", i), 64'(wbData), 64'(vecs[i].expWbData));
         checkOutput($sformatf("vec%0d_wb_en", i), 64'(wbEn), 64'(vecs[i].expWbEn));
         checkOutput($sformatf("vec%0d_rs1", i), 64'(rs1Data), 64'(vecs[i].expRs1));
         checkOutput($sformatf("vec%0d_rs2", i), 64'(rs2Data), 64'(vecs[i].expRs2));
         checkOutput($sformatf("vec%0d_instret", i), instret, vecs[i].expCnt);
         modelCommit();
         @(posedge clk);
         #1;
      end

      // Write x5, then assert reset mid-cycle while a write to x6 is pending
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h00001234, 32'h0, 5'd5, 5'd5, 5'd0);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000BEEF, 32'h0, 5'd6, 5'd5, 5'd6);
      #1;
      checkOutput("x5_written", 64'(rs1Data), 64'h1234);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("async_reset_x5", 64'(rs1Data), 64'd0);
      checkOutput("async_reset_instret", instret, 64'd0);
      checkOutput("async_reset_instret8", 64'(instret8), 64'd0);
      @(posedge clk);
      #1;
      valid = 1'b0;
      #2;
      rstN = 1'b1;
      modelReset();
      #1;
      checkOutput("pending_write_dropped_x6", 64'(rs2Data), 64'd0);
      checkOutput("post_reset_x5", 64'(rs1Data), 64'd0);
      @(posedge clk);
      #1;

      // First edge after release commits and counts normally
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h00000077, 32'h0, 5'd10, 5'd10, 5'd0);
      modelCommit();
      @(posedge clk);
      #1;
      valid = 1'b0;
      #1;
      checkOutput("first_edge_x10", 64'(rs1Data), 64'h77);
      checkOutput("first_edge_instret", instret, 64'd1);

      // Bubble with unknown controls and data must not disturb state
      valid    = 1'b0;
      regWrite = 1'bx;
      memToReg = 1'bx;
      data     = 'x;
      readData = 'x;
      rd       = 'x;
      rs1      = 5'd10;
      rs2      = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("xbubble_x10", 64'(rs1Data), 64'h77);
      checkOutput("xbubble_instret", instret, 64'd1);
      checkOutput("xbubble_wb_en", 64'(wbEn), 64'd0);

      // Randomized traffic against the model; the 8-bit counter wraps here
      for (int n = 0; n < 600; n++) begin
         logic [4:0] dst;
         dst = 5'($urandom_range(0, 31));
         applyStimulus(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom, $urandom, dst,
                       ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 3) == 0) ? dst : 5'($urandom_range(0, 31)));
         #2;
         checkOutput("rand_wb_data", 64'(wbData), 64'(memToReg ? readData : data));
         checkOutput("rand_wb_en", 64'(wbEn), 64'(valid && regWrite && (rd != 5'd0)));
         checkOutput("rand_rs1", 64'(rs1Data), 64'(expRead(rs1)));
         checkOutput("rand_rs2", 64'(rs2Data), 64'(expRead(rs2)));
         checkOutput("rand_instret", instret, modelCnt);
         checkOutput("rand_instret8", 64'(instret8), 64'(modelCnt % 64'd256));
         checkOutput("rand_rs1_b", 64'(rs1Data8), 64'(expRead(rs1)));
         checkOutput("rand_rs2_b", 64'(rs2Data8), 64'(expRead(rs2)));
         checkOutput("rand_wb_b", {31'd0, wbEn8, wbData8}, {31'd0, (valid && regWrite && (rd != 5'd0)), (memToReg ? readData : data)});
         modelCommit();
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register: consumes the latched MEM/WB controls and data, selects the write-back value and commits it to a 32x32 integer register file.
- Provides the two combinational read ports used by the ID stage.
- Maintains a retired-instruction counter.
- Sits between the MEM/WB register and ID-stage operand fetch.

Parameters:
- XLEN, 32, data width of registers and write-back paths
- NREG, 32, number of architectural registers (x0 hardwired to zero)
- CNT_W, 64, width of retired-instruction counter

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately, release is synchronous to clk_i by system
- valid_i  in  1  MEM/WB slot holds a real instruction (0 = bubble)
- RegWrite_i  in  1  instruction writes rd
- MemtoReg_i  in  1  1 = write Readdata_i, 0 = write data_i
- data_i  in  XLEN  ALU result from MEM/WB
- Readdata_i  in  XLEN  load data from MEM/WB
- rd_i  in  5  destination register index
- rs1_i  in  5  read port 1 index
- rs2_i  in  5  read port 2 index
- rs1_data_o  out  XLEN  read port 1 data
- rs2_data_o  out  XLEN  read port 2 data
- wb_data_o  out  XLEN  selected write-back value (to forwarding unit)
- wb_en_o  out  1  effective write enable this cycle
- instret_o  out  CNT_W  count of retired non-bubble instructions

Behaviour:
- Write-back mux (combinational): wb_data_o = MemtoReg_i ? Readdata_i : data_i.
- Write enable (combinational): wb_en_o = valid_i & RegWrite_i & (rd_i != 0).
- Commit: on rising clk_i with wb_en_o = 1, regs[rd_i] <= wb_data_o. Latency is one cycle from presentation to architectural visibility without bypass.
- x0 is never written; reads of index 0 return 0 regardless of any write.
- Read ports are combinational from regs; both ports may address the same register.
- Counter: on rising clk_i with valid_i = 1, instret_o <= instret_o + 1.
  - Increments regardless of RegWrite_i (stores and branches retire too).
  - Wraps modulo 2^CNT_W; no saturation.
- Bubble: valid_i = 0 writes nothing and leaves the counter unchanged. Other inputs are don't-care except for wb_data_o.
- Reset (rst_i = 0, asynchronous):
  - all regs[1..31] <= 0 and instret_o <= 0 immediately, independent of clk_i;
  - rs1_data_o and rs2_data_o read 0 while reset is held.
- Reset asserted mid-cycle during a pending write: the write is discarded; state is 0 after release.
- First rising edge after rst_i rises: normal commit and count.
- Inputs contain X while valid_i = 0: no state change, no X propagated into regs or instret_o.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: internal write-before-read forwarding. If wb_en_o = 1 and rs1_i == rd_i, then rs1_data_o = wb_data_o in the same cycle; rs2 likewise. Index 0 still returns 0.
- Undefined: read ports always return stored regs contents; same-cycle readers see the old value until the next cycle. The hazard unit must cover this with a stall or external forwarding.

Test Plan:
- Reset: hold rst_i=0 with clk toggling -> all 32 reads = 0 and instret_o = 0. Assert rst_i mid-cycle after writing x5=0x1234 -> x5 reads 0 immediately.
- ALU write then load write:
  - valid=1, RegWrite=1, MemtoReg=0, data_i=0xDEADBEEF, rd=3 -> next cycle rs1=3 reads 0xDEADBEEF.
  - Then MemtoReg=1, Readdata_i=0x00C0FFEE, rd=4 -> x4 = 0x00C0FFEE.
- x0 protection: write rd=0, data_i=0xFFFFFFFF -> wb_en_o=0, rs1=0 reads 0, instret_o increments by 1.
- Bubble: valid=0, RegWrite=1, rd=7, data_i=0x55 -> x7 unchanged and instret_o unchanged.
- Bypass:
  - Write rd=9 = 0xA5A5A5A5 with rs1=rs2=9 in the same cycle.
  - With WB_BYPASS_EN: both ports show 0xA5A5A5A5 that cycle.
  - Without: both show the old value (0), then 0xA5A5A5A5 the next cycle.
- Counter wrap: force instret_o to 0xFFFF_FFFF_FFFF_FFFF (CNT_W=64), retire one instruction -> instret_o = 0.
